// File: rtl/vision_pkg.sv
// Shared definitions for the vision pipeline stages: default geometry,
// accumulator sizing, the coefficient bank type and the rounding and
// saturation helpers used by the output stage of the filters.
package vision_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_KERNEL_SIZE = 3;
    localparam int DEF_COEF_WIDTH  = 8;
    localparam int DEF_SHIFT_WIDTH = 4;
    localparam int DEF_TAPS        = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;

    // Accumulator width for a K x K sum of (unsigned pixel x signed coef)
    // products: one sign bit for the zero-extended pixel plus enough growth
    // bits that the full sum can never wrap.
    function automatic int acc_width(input int data_width,
                                     input int coef_width,
                                     input int kernel_size);
        return data_width + coef_width + 1 + $clog2(kernel_size * kernel_size);
    endfunction

    localparam int DEF_ACC_WIDTH = acc_width(DEF_DATA_WIDTH, DEF_COEF_WIDTH,
                                             DEF_KERNEL_SIZE);

    // Coefficient bank for the default geometry, tap index = row*K + col.
    typedef logic signed [DEF_COEF_WIDTH-1:0] coef_bank_t [DEF_TAPS];

    // Identity kernel: centre tap 1, every other tap 0.
    function automatic int identity_tap(input int idx, input int kernel_size);
        return (idx == (kernel_size * kernel_size) / 2) ? 1 : 0;
    endfunction

    // Round-half-up arithmetic right shift: add half an LSB of the result
    // before shifting so that .5 fractions round towards +infinity.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] value,
                                                       input int shift);
        logic signed [63:0] bias;
        bias = 64'sd0;
        if (shift > 0) begin
            bias = 64'sd1 <<< (shift - 1);
        end
        return (value + bias) >>> shift;
    endfunction

    // Clamp a signed value into the unsigned range [0, 2^width - 1].
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int width);
        logic signed [63:0] max_val;
        max_val = (64'sd1 <<< width) - 64'sd1;
        if (value < 64'sd0) begin
            return 64'sd0;
        end
        if (value > max_val) begin
            return max_val;
        end
        return value;
    endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Two-level registered signed reduction of N_TERMS products. Level 1 sums
// groups of GROUP terms (one kernel row each for a convolution), level 2
// adds the group sums. A sideband word travels alongside with the same
// two-cycle latency so callers can keep per-sample metadata aligned.
module conv_adder_tree
    import vision_pkg::*;
#(
    parameter int N_TERMS    = DEF_TAPS,
    parameter int GROUP      = DEF_KERNEL_SIZE,
    parameter int IN_WIDTH   = DEF_DATA_WIDTH + DEF_COEF_WIDTH + 1,
    parameter int OUT_WIDTH  = DEF_ACC_WIDTH,
    parameter int SIDE_WIDTH = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid_i,
    input  logic [N_TERMS-1:0][IN_WIDTH-1:0]     terms_i,
    input  logic [SIDE_WIDTH-1:0]                side_i,
    output logic                                 out_valid_o,
    output logic signed [OUT_WIDTH-1:0]          sum_o,
    output logic [SIDE_WIDTH-1:0]                side_o
);

    localparam int N_GROUPS = (N_TERMS + GROUP - 1) / GROUP;

    logic signed [OUT_WIDTH-1:0] group_d [N_GROUPS];
    logic signed [OUT_WIDTH-1:0] group_q [N_GROUPS];
    logic                        lvl1_valid_q;
    logic [SIDE_WIDTH-1:0]       lvl1_side_q;

    logic signed [OUT_WIDTH-1:0] sum_d;
    logic signed [OUT_WIDTH-1:0] sum_q;
    logic                        lvl2_valid_q;
    logic [SIDE_WIDTH-1:0]       lvl2_side_q;

    // Level 1: sign-extend each product and add it into its group.
    always_comb begin
        for (int g = 0; g < N_GROUPS; g++) begin
            group_d[g] = '0;
            for (int t = 0; t < GROUP; t++) begin
                if (g * GROUP + t < N_TERMS) begin
                    group_d[g] = group_d[g]
                               + OUT_WIDTH'($signed(terms_i[g * GROUP + t]));
                end
            end
        end
    end

    // Level 1 register: group partial sums, valid and sideband.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int g = 0; g < N_GROUPS; g++) begin
                group_q[g] <= '0;
            end
            lvl1_valid_q <= 1'b0;
            lvl1_side_q  <= '0;
        end else begin
            for (int g = 0; g < N_GROUPS; g++) begin
                group_q[g] <= group_d[g];
            end
            lvl1_valid_q <= in_valid_i;
            lvl1_side_q  <= side_i;
        end
    end

    // Level 2: add the group partial sums.
    always_comb begin
        sum_d = '0;
        for (int g = 0; g < N_GROUPS; g++) begin
            sum_d = sum_d + group_q[g];
        end
    end

    // Level 2 register: final sum, valid and sideband.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q        <= '0;
            lvl2_valid_q <= 1'b0;
            lvl2_side_q  <= '0;
        end else begin
            sum_q        <= sum_d;
            lvl2_valid_q <= lvl1_valid_q;
            lvl2_side_q  <= lvl1_side_q;
        end
    end

    assign out_valid_o = lvl2_valid_q;
    assign sum_o       = sum_q;
    assign side_o      = lvl2_side_q;

endmodule

// File: rtl/conv3x3_filter.sv
// K x K convolution stage fed by the line buffer window stream. Products
// are formed with the kernel in force for each window and registered, the
// adder tree reduces them over two cycles, and the output stage rounds,
// normalises and saturates: a window accepted at edge N is output at N+3.
// Coefficients are double-banked; a committed shadow bank becomes active
// only on a frame_start so a frame never mixes kernels.
module conv3x3_filter
    import vision_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int COEF_WIDTH  = DEF_COEF_WIDTH,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   frame_start,
    input  logic [15:0]                                            img_width,
    input  logic                                                   window_valid,
    input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] window_data,
    input  logic                                                   coef_wr_en,
    input  logic [3:0]                                             coef_wr_addr,
    input  logic signed [COEF_WIDTH-1:0]                           coef_wr_data,
    input  logic [SHIFT_WIDTH-1:0]                                 shift_wr,
    input  logic                                                   coef_commit,
    output logic                                                   pixel_valid,
    output logic [DATA_WIDTH-1:0]                                  pixel_data,
    output logic                                                   pixel_last,
    output logic                                                   commit_pending
);

    localparam int TAPS      = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PROD_W    = DATA_WIDTH + 1 + COEF_WIDTH;
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COEF_WIDTH, KERNEL_SIZE);
    localparam int SIDE_W    = SHIFT_WIDTH + 1;

    // ---------------- coefficient banks ----------------
    logic signed [COEF_WIDTH-1:0] shadow_coef_q [TAPS];
    logic signed [COEF_WIDTH-1:0] shadow_coef_d [TAPS];
    logic signed [COEF_WIDTH-1:0] active_coef_q [TAPS];
    logic signed [COEF_WIDTH-1:0] active_coef_d [TAPS];
    logic [SHIFT_WIDTH-1:0]       shadow_shift_q, shadow_shift_d;
    logic [SHIFT_WIDTH-1:0]       active_shift_q, active_shift_d;
    logic                         pending_q, pending_d;
    logic                         apply_commit;

    // A swap happens on frame_start if a commit is outstanding or arrives
    // in the same cycle.
    assign apply_commit = frame_start && (pending_q || coef_commit);

    // Shadow writes, commit bookkeeping and the shadow-to-active swap. The
    // swap uses the next shadow value so a same-cycle write is included,
    // and active_*_d doubles as the kernel applied to this cycle's window.
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            shadow_coef_d[i] = shadow_coef_q[i];
            if (coef_wr_en && (int'(coef_wr_addr) == i)) begin
                shadow_coef_d[i] = coef_wr_data;
            end
        end
        shadow_shift_d = coef_commit ? shift_wr : shadow_shift_q;
        for (int i = 0; i < TAPS; i++) begin
            active_coef_d[i] = apply_commit ? shadow_coef_d[i] : active_coef_q[i];
        end
        active_shift_d = apply_commit ? shadow_shift_d : active_shift_q;
        if (apply_commit) begin
            pending_d = 1'b0;
        end else if (coef_commit) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Coefficient bank registers; both banks reset to the identity kernel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                shadow_coef_q[i] <= COEF_WIDTH'(identity_tap(i, KERNEL_SIZE));
                active_coef_q[i] <= COEF_WIDTH'(identity_tap(i, KERNEL_SIZE));
            end
            shadow_shift_q <= '0;
            active_shift_q <= '0;
            pending_q      <= 1'b0;
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                shadow_coef_q[i] <= shadow_coef_d[i];
                active_coef_q[i] <= active_coef_d[i];
            end
            shadow_shift_q <= shadow_shift_d;
            active_shift_q <= active_shift_d;
            pending_q      <= pending_d;
        end
    end

    assign commit_pending = pending_q;

    // ---------------- column counter / last flag ----------------
    logic [15:0] col_q, col_d, col_cur;
    logic [16:0] last_col;
    logic        win_last;

    // frame_start forces column 0, including for a window in the same
    // cycle. Narrow images (width <= K) produce one window per row.
    always_comb begin
        col_cur  = frame_start ? 16'd0 : col_q;
        last_col = {1'b0, img_width} - 17'(KERNEL_SIZE);
        win_last = ({1'b0, img_width} <= 17'(KERNEL_SIZE))
                || ({1'b0, col_cur} == last_col);
        col_d    = col_q;
        if (window_valid) begin
            col_d = win_last ? 16'd0 : col_cur + 16'd1;
        end else if (frame_start) begin
            col_d = 16'd0;
        end
    end

    // Column counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end

    // ---------------- stage 1: products ----------------
    logic [TAPS-1:0][PROD_W-1:0] prod_d;
    logic [TAPS-1:0][PROD_W-1:0] prod_q;
    logic                        s1_valid_q;
    logic                        s1_last_q;
    logic [SHIFT_WIDTH-1:0]      s1_shift_q;

    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
        logic signed [PROD_W-1:0] pix_ext;
        logic signed [PROD_W-1:0] coef_ext;
        // Pixel is zero-extended so it stays positive in signed arithmetic.
        assign pix_ext    = PROD_W'({1'b0, window_data[gi / KERNEL_SIZE][gi % KERNEL_SIZE]});
        assign coef_ext   = PROD_W'(active_coef_d[gi]);
        assign prod_d[gi] = pix_ext * coef_ext;
    end

    // Stage 1 register: products plus the shift and last flag of the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_shift_q <= '0;
        end else begin
            prod_q     <= prod_d;
            s1_valid_q <= window_valid;
            s1_last_q  <= window_valid && win_last;
            s1_shift_q <= active_shift_d;
        end
    end

    // ---------------- stage 2: adder tree ----------------
    logic                        tree_valid;
    logic signed [ACC_WIDTH-1:0] tree_sum;
    logic [SIDE_W-1:0]           tree_side;

    conv_adder_tree #(
        .N_TERMS    (TAPS),
        .GROUP      (KERNEL_SIZE),
        .IN_WIDTH   (PROD_W),
        .OUT_WIDTH  (ACC_WIDTH),
        .SIDE_WIDTH (SIDE_W)
    ) u_tree (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s1_valid_q),
        .terms_i     (prod_q),
        .side_i      ({s1_shift_q, s1_last_q}),
        .out_valid_o (tree_valid),
        .sum_o       (tree_sum),
        .side_o      (tree_side)
    );

    // ---------------- stage 3: normalise and saturate ----------------
    logic signed [63:0]    rounded;
    logic signed [63:0]    clamped;
    logic                  pixel_valid_q, pixel_valid_d;
    logic                  pixel_last_q, pixel_last_d;
    logic [DATA_WIDTH-1:0] pixel_data_q, pixel_data_d;

    // Round-half-up shift by the shift captured with the window, then clamp.
    always_comb begin
        rounded       = round_shift(64'(tree_sum), int'(tree_side[SIDE_W-1:1]));
        clamped       = saturate(rounded, DATA_WIDTH);
        pixel_valid_d = tree_valid;
        pixel_last_d  = tree_valid && tree_side[0];
        pixel_data_d  = tree_valid ? DATA_WIDTH'(clamped) : pixel_data_q;
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_valid_q <= 1'b0;
            pixel_last_q  <= 1'b0;
            pixel_data_q  <= '0;
        end else begin
            pixel_valid_q <= pixel_valid_d;
            pixel_last_q  <= pixel_last_d;
            pixel_data_q  <= pixel_data_d;
        end
    end

    assign pixel_valid = pixel_valid_q;
    assign pixel_last  = pixel_last_q;
    assign pixel_data  = pixel_data_q;

endmodule

// File: tb/tb_conv3x3_filter.sv
// Directed bench for conv3x3_filter: a table of windows with hand-computed
// results, plus sequences for row-end flags, frame-boundary commits and
// reset with data in flight.
module tb_conv3x3_filter;

    typedef logic [2:0][2:0][7:0] win_t;
    typedef struct {
        int         kern;
        win_t       win;
        logic [7:0] exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic [15:0]       img_width;
    logic              window_valid;
    win_t              window_data;
    logic              coef_wr_en;
    logic [3:0]        coef_wr_addr;
    logic signed [7:0] coef_wr_data;
    logic [3:0]        shift_wr;
    logic              coef_commit;
    logic              pixel_valid;
    logic [7:0]        pixel_data;
    logic              pixel_last;
    logic              commit_pending;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    conv3x3_filter dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .img_width      (img_width),
        .window_valid   (window_valid),
        .window_data    (window_data),
        .coef_wr_en     (coef_wr_en),
        .coef_wr_addr   (coef_wr_addr),
        .coef_wr_data   (coef_wr_data),
        .shift_wr       (shift_wr),
        .coef_commit    (coef_commit),
        .pixel_valid    (pixel_valid),
        .pixel_data     (pixel_data),
        .pixel_last     (pixel_last),
        .commit_pending (commit_pending)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic win_t mk_cols(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        win_t w;
        for (int r = 0; r < 3; r++) begin
            w[r][0] = a;
            w[r][1] = b;
            w[r][2] = c;
        end
        return w;
    endfunction

    function automatic win_t mk_centre(input logic [7:0] c, input logic [7:0] other);
        win_t w;
        w = mk_cols(other, other, other);
        w[1][1] = c;
        return w;
    endfunction

    // Kernel 0 identity, 1 box (all ones, shift 3), 2 Sobel-x (shift 0).
    function automatic logic signed [7:0] kcoef(input int kern, input int idx);
        int row, col, mag;
        row = idx / 3;
        col = idx % 3;
        mag = (row == 1) ? 2 : 1;
        if (kern == 1) return 8'sd1;
        if (kern == 2) return 8'((col == 0) ? -mag : ((col == 2) ? mag : 0));
        return (idx == 4) ? 8'sd1 : 8'sd0;
    endfunction

    function automatic logic [3:0] kshift(input int kern);
        return (kern == 1) ? 4'd3 : 4'd0;
    endfunction

    task automatic write_kernel(input int kern);
        for (int idx = 0; idx < 9; idx++) begin
            coef_wr_en   = 1'b1;
            coef_wr_addr = 4'(idx);
            coef_wr_data = kcoef(kern, idx);
            tick();
        end
        coef_wr_en  = 1'b0;
        coef_commit = 1'b1;
        shift_wr    = kshift(kern);
        tick();
        coef_commit = 1'b0;
        check("pending_set", 32'(commit_pending), 32'd1);
    endtask

    task automatic program_kernel(input int kern);
        write_kernel(kern);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("pending_clear", 32'(commit_pending), 32'd0);
    endtask

    task automatic run_vec(input string name, input win_t w, input logic [7:0] exp);
        window_valid = 1'b1;
        window_data  = w;
        tick();
        window_valid = 1'b0;
        tick();
        tick();
        check({name, "_early"}, 32'(pixel_valid), 32'd0);
        tick();
        check({name, "_valid"}, 32'(pixel_valid), 32'd1);
        check({name, "_data"}, 32'(pixel_data), 32'(exp));
    endtask

    initial begin
        int         cur_kern;
        int         out_n;
        logic [7:0] exp_q[$];

        // ---- vector table ----
        for (int c = 0; c < 64; c++) begin
            vecs.push_back('{0, mk_centre(8'(c), 8'd200), 8'(c)});
        end
        vecs.push_back('{1, mk_cols(8'd80, 8'd80, 8'd80),    8'd90});
        vecs.push_back('{1, mk_cols(8'd255, 8'd255, 8'd255), 8'd255});
        vecs.push_back('{1, mk_centre(8'd12, 8'd0),          8'd2});
        vecs.push_back('{1, mk_centre(8'd11, 8'd0),          8'd1});
        vecs.push_back('{1, mk_cols(8'd10, 8'd20, 8'd30),    8'd23});
        vecs.push_back('{2, mk_cols(8'd0, 8'd0, 8'd255),     8'd255});
        vecs.push_back('{2, mk_cols(8'd255, 8'd0, 8'd0),     8'd0});
        vecs.push_back('{2, mk_cols(8'd100, 8'd100, 8'd100), 8'd0});
        vecs.push_back('{2, mk_cols(8'd10, 8'd0, 8'd30),     8'd80});

        // ---- reset ----
        rst          = 1'b1;
        frame_start  = 1'b0;
        img_width    = 16'd8;
        window_valid = 1'b0;
        window_data  = '0;
        coef_wr_en   = 1'b0;
        coef_wr_addr = '0;
        coef_wr_data = '0;
        shift_wr     = '0;
        coef_commit  = 1'b0;
        tick();
        tick();
        check("rst_valid",   32'(pixel_valid),    32'd0);
        check("rst_data",    32'(pixel_data),     32'd0);
        check("rst_last",    32'(pixel_last),     32'd0);
        check("rst_pending", 32'(commit_pending), 32'd0);
        rst = 1'b0;
        tick();

        // ---- table-driven vectors ----
        cur_kern = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].kern != cur_kern) begin
                program_kernel(vecs[i].kern);
                cur_kern = vecs[i].kern;
            end
            $display("vec %0d kern %0d exp %0d", i, vecs[i].kern, vecs[i].exp);
            run_vec($sformatf("vec%0d", i), vecs[i].win, vecs[i].exp);
        end

        // ---- row-end flag, width 8: every 6th output is last ----
        img_width = 16'd8;
        out_n = 0;
        for (int c = 0; c < 40; c++) begin
            window_valid = (c < 36);
            frame_start  = (c == 0);
            window_data  = mk_cols(8'd1, 8'd2, 8'd3);
            tick();
            if (pixel_valid) begin
                out_n++;
                check($sformatf("last_w8_out%0d", out_n), 32'(pixel_last), 32'((out_n % 6) == 0));
            end
        end
        window_valid = 1'b0;
        frame_start  = 1'b0;
        check("last_w8_count", 32'(out_n), 32'd36);

        // ---- frame_start mid-row restarts the count ----
        out_n = 0;
        for (int c = 0; c < 13; c++) begin
            window_valid = (c < 9);
            frame_start  = (c == 3);
            tick();
            if (pixel_valid) begin
                out_n++;
                check($sformatf("restart_out%0d", out_n), 32'(pixel_last), 32'(out_n == 9));
            end
        end
        window_valid = 1'b0;
        frame_start  = 1'b0;
        check("restart_count", 32'(out_n), 32'd9);

        // ---- narrow image: every window is last ----
        img_width = 16'd3;
        out_n = 0;
        for (int c = 0; c < 7; c++) begin
            window_valid = (c < 3);
            tick();
            if (pixel_valid) begin
                out_n++;
                check($sformatf("narrow_out%0d", out_n), 32'(pixel_last), 32'd1);
            end
        end
        window_valid = 1'b0;
        check("narrow_count", 32'(out_n), 32'd3);
        img_width = 16'd8;

        // ---- commit mid-frame takes effect at the next frame_start ----
        program_kernel(0);
        write_kernel(1);
        exp_q = '{8'd80, 8'd90, 8'd90};
        out_n = 0;
        for (int c = 0; c < 8; c++) begin
            window_valid = (c < 3);
            frame_start  = (c == 1);
            window_data  = mk_cols(8'd80, 8'd80, 8'd80);
            tick();
            if (c == 0) check("commit_hold_pending", 32'(commit_pending), 32'd1);
            if (c == 1) check("commit_applied_pending", 32'(commit_pending), 32'd0);
            if (pixel_valid) begin
                if (out_n < 3) begin
                    check($sformatf("commit_out%0d", out_n), 32'(pixel_data), 32'(exp_q[out_n]));
                end
                out_n++;
            end
        end
        window_valid = 1'b0;
        frame_start  = 1'b0;
        check("commit_count", 32'(out_n), 32'd3);

        // ---- reset with three windows in flight ----
        write_kernel(2);
        for (int c = 0; c < 10; c++) begin
            window_valid = (c < 3);
            rst          = (c == 3);
            window_data  = mk_cols(8'd80, 8'd80, 8'd80);
            tick();
            check($sformatf("rst_flight_c%0d", c), 32'(pixel_valid), 32'd0);
            if (c == 3) begin
                check("rst_flight_pending", 32'(commit_pending), 32'd0);
                check("rst_flight_data",    32'(pixel_data),     32'd0);
                check("rst_flight_last",    32'(pixel_last),     32'd0);
            end
        end
        rst          = 1'b0;
        window_valid = 1'b0;
        frame_start  = 1'b1;
        tick();
        frame_start  = 1'b0;
        run_vec("post_rst_identity", mk_centre(8'd77, 8'd200), 8'd77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv3x3_filter.md
Name: conv3x3_filter

Overview:
- Pipelined 2-D convolution stage directly downstream of line_buffer; consumes its KERNEL_SIZE x KERNEL_SIZE window stream.
- Emits one filtered pixel per valid window.
- Runtime-programmable signed coefficients and a right-shift normaliser, with output saturation.
- Coefficient changes take effect only at frame boundaries, so a frame is never filtered with mixed kernels.

Parameters:
- DATA_WIDTH, 8: unsigned pixel width, input and output.
- KERNEL_SIZE, 3: window dimension; must match the upstream line_buffer.
- COEF_WIDTH, 8: signed two's-complement coefficient width.
- SHIFT_WIDTH, 4: width of the normalisation shift amount.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  single-cycle pulse at frame start; same pulse that drives line_buffer.
- img_width  in  16  active image width in pixels.
- window_valid  in  1  window_data valid this cycle.
- window_data  in  [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0]  window indexed [row][col]; row 0 is the oldest line.
- coef_wr_en  in  1  write one shadow coefficient.
- coef_wr_addr  in  4  coefficient index = row*KERNEL_SIZE+col.
- coef_wr_data  in  COEF_WIDTH  signed coefficient.
- shift_wr  in  SHIFT_WIDTH  shadow shift amount; sampled on coef_commit.
- coef_commit  in  1  request shadow-to-active transfer at the next frame_start.
- pixel_valid  out  1  output pixel valid.
- pixel_data  out  DATA_WIDTH  filtered pixel.
- pixel_last  out  1  last output pixel of the current row.
- commit_pending  out  1  commit requested, not yet applied.

Behaviour:
- Reset values: pixel_valid=0, pixel_data=0, pixel_last=0, commit_pending=0.
  - Active and shadow coefficients = identity (centre=1, all others 0); active and shadow shift = 0.
  - All pipeline valids cleared; column counter = 0.
  - Reset mid-stream: in-flight results are discarded, nothing emitted afterwards.
- Pipeline: fixed latency 3, no backpressure, one window accepted per cycle.
  - Window accepted at edge N appears on pixel_valid/pixel_data at edge N+3.
  - Stage 1: K*K products, each = zero-extended pixel (DATA_WIDTH+1 signed) x signed coefficient.
  - Stage 2: signed adder tree; ACC_WIDTH = DATA_WIDTH+COEF_WIDTH+1+clog2(K*K), 21 for defaults. Sum never wraps.
  - Stage 3: round-half-up arithmetic right shift by active shift (add 1<<(shift-1) first when shift>0), then saturate.
  - Saturation: result <0 -> 0; result >2^DATA_WIDTH-1 -> 2^DATA_WIDTH-1.
- pixel_last is computed at input acceptance and carried through the pipeline.
  - Column counter increments per accepted window.
  - When count == img_width-KERNEL_SIZE: flag that window last, wrap counter to 0.
  - If img_width <= KERNEL_SIZE, every window is last.
- frame_start resets the column counter.
  - frame_start and window_valid in the same cycle: the window counts as column 0 of the new frame.
  - In-flight pixels of the previous frame complete normally, using the old coefficients latched with them.
- Coefficient path:
  - coef_wr_en writes the shadow bank at any time; addresses >= K*K are ignored.
  - coef_commit sets commit_pending and latches shift_wr into the shadow shift.
  - On a frame_start cycle with pending set (or coef_commit in the same cycle): active <= shadow; commit_pending clears the next cycle.
  - coef_wr_en and coef_commit in the same cycle: the written value is included in the commit.
  - Active coefficients and shift are captured per window in stage 1, so a mid-pipeline swap never corrupts in-flight data.
- frame_start while pixel_valid is outputting: both proceed, no stall.

Decomposition:
- Package vision_pkg:
  - ACC_WIDTH function of parameters.
  - Coefficient-bank typedef (array of K*K signed COEF_WIDTH).
  - Identity-kernel constant.
  - Saturate/round helper functions.
- One natural sub-module, conv_adder_tree: registered signed reduction of K*K products, reusable by later Sobel/median stages.

Test Plan:
- After reset, windows with centre = 0,1,...,63 (all others 200) -> pixel_data = centre value exactly, 3 cycles after each window_valid.
- All coefficients=1, shift=3, commit, frame_start, all-80 window -> 720 >> 3 = 90; all-255 window -> 2295 >> 3 rounds to 287, saturates to 255.
- Sobel-x (-1,0,1;-2,0,2;-1,0,1), shift 0:
  - columns 0/0/255 -> 1020 -> 255.
  - columns 255/0/0 -> -1020 -> 0.
  - flat window -> 0.
- img_width=8, 36 consecutive windows -> pixel_last on the 6th, 12th, ... 36th output only; a frame_start mid-row restarts the count.
- coef_commit mid-frame:
  - outputs keep the old kernel and commit_pending=1 until the next frame_start.
  - the first window of the new frame uses the new kernel; commit_pending then returns to 0.
- rst asserted with 3 windows in flight -> no pixel_valid for those windows, kernel reverts to identity, commit_pending=0.
